asyndram_wr_ctrl: RTL and testbench

ASYNDRAM_WR_CTRL -- requirements
Module: asyndram_wr_ctrl

---
 rtl/asyndram_wr_ctrl.sv | 121 ++++++++++++
 tb/tb_asyndram_wr_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/asyndram_wr_ctrl.sv
// Write side of an async dual-clock RAM FIFO: one-cycle registered write port, Gray pointer export.
// Level/full see the reader 3 clkb edges after its pointer changes; words offered while full are dropped and flagged in ovf.
module asyndram_wr_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AFULL_LVL  = 12,
  parameter int DATA_DEPTH = 1 << ADDR_WIDTH
) (
  input  logic                  clkb,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic                  wrenb_n,
  output logic                  csen_n,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int PW = ADDR_WIDTH + 1;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0]         wr_bin_q, wr_bin_d;
  logic [PW-1:0]         sync1_q, sync1_d;
  logic [PW-1:0]         sync2_q, sync2_d;
  logic [PW-1:0]         rd_bin_s_q, rd_bin_s_d;
  logic [PW-1:0]         wr_ptr_gray_q, wr_ptr_gray_d;
  logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
  logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
  logic                  wrenb_n_q, wrenb_n_d;
  logic                  csen_n_q, csen_n_d;
  logic [PW-1:0]         wr_level_q, wr_level_d;
  logic                  full_q, full_d;
  logic                  almost_full_q, almost_full_d;
  logic                  ovf_q, ovf_d;
  logic                  accept;

  always_comb begin
    accept        = in_valid && !full_q;
    wr_bin_d      = wr_bin_q + PW'(accept);
    sync1_d       = rd_ptr_gray;
    sync2_d       = sync1_q;
    rd_bin_s_d    = gray2bin(sync2_q);
    // Advertised from the pre-edge pointer so the reader never sees a word the RAM has not yet captured.
    wr_ptr_gray_d = wr_bin_q ^ (wr_bin_q >> 1);
    addr_b_d      = addr_b_q;
    data_b_d      = data_b_q;
    wrenb_n_d     = 1'b1;
    if (accept) begin
      addr_b_d  = wr_bin_q[ADDR_WIDTH-1:0];
      data_b_d  = in_data;
      wrenb_n_d = 1'b0;
    end
    wr_level_d    = wr_bin_d - rd_bin_s_d;
    full_d        = (wr_level_d == PW'(DATA_DEPTH));
    almost_full_d = (wr_level_d >= PW'(AFULL_LVL));
    ovf_d         = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (in_valid && full_q) ovf_d = 1'b1;
    csen_n_d      = 1'b0;
  end

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin_q      <= '0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      rd_bin_s_q    <= '0;
      wr_ptr_gray_q <= '0;
      addr_b_q      <= '0;
      data_b_q      <= '0;
      wrenb_n_q     <= 1'b1;
      csen_n_q      <= 1'b1;
      wr_level_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      wr_bin_q      <= wr_bin_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      rd_bin_s_q    <= rd_bin_s_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      addr_b_q      <= addr_b_d;
      data_b_q      <= data_b_d;
      wrenb_n_q     <= wrenb_n_d;
      csen_n_q      <= csen_n_d;
      wr_level_q    <= wr_level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      ovf_q         <= ovf_d;
    end
  end

  assign in_ready    = ~full_q;
  assign wr_ptr_gray = wr_ptr_gray_q;
  assign addr_b      = addr_b_q;
  assign data_b      = data_b_q;
  assign wrenb_n     = wrenb_n_q;
  assign csen_n      = csen_n_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wr_level    = wr_level_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_asyndram_wr_ctrl.sv
// Bench for asyndram_wr_ctrl: word-count model checked every cycle plus directed literal checks.
module tb_asyndram_wr_ctrl;

  logic       clkb = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [4:0] rd_ptr_gray;
  logic [4:0] wr_ptr_gray;
  logic [3:0] addr_b;
  logic [7:0] data_b;
  logic       wrenb_n;
  logic       csen_n;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic       ovf;
  logic       ovf_clr;

  int n_chk  = 0;
  int n_fail = 0;

  asyndram_wr_ctrl dut (
    .clkb(clkb), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rd_ptr_gray(rd_ptr_gray), .wr_ptr_gray(wr_ptr_gray),
    .addr_b(addr_b), .data_b(data_b), .wrenb_n(wrenb_n), .csen_n(csen_n),
    .full(full), .almost_full(almost_full), .wr_level(wr_level), .ovf(ovf),
    .ovf_clr(ovf_clr)
  );

  always #5 clkb = ~clkb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    for (int i = 0; i < 5; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  // Model: count of words accepted, reader pointer as seen two edges late, derived flags.
  logic [4:0] m_wr, m_old_wr, m_rd_seen, m_level, rd_h1, rd_h2;
  logic       m_full, m_old_full, m_af, m_ovf, m_we_n, m_cs_n;
  logic [3:0] m_addr;
  logic [7:0] m_data;
  logic [4:0] m_gray;

  always @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      m_wr = 0; rd_h1 = 0; rd_h2 = 0; m_level = 0; m_full = 0; m_af = 0;
      m_ovf = 0; m_we_n = 1; m_cs_n = 1; m_addr = 0; m_data = 0; m_gray = 0;
    end else begin
      m_old_wr   = m_wr;
      m_old_full = m_full;
      m_rd_seen  = g2b(rd_h2);
      rd_h2      = rd_h1;
      rd_h1      = rd_ptr_gray;
      if (in_valid && !m_old_full) begin
        m_addr = m_wr[3:0];
        m_data = in_data;
        m_we_n = 0;
        m_wr   = m_wr + 5'd1;
      end else begin
        m_we_n = 1;
      end
      m_gray  = b2g(m_old_wr);
      m_level = m_wr - m_rd_seen;
      m_full  = (m_level == 5'd16);
      m_af    = (m_level >= 5'd12);
      if (in_valid && m_old_full) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      m_cs_n  = 0;
    end
  end

  always @(negedge clkb) begin
    chk("model_wrenb_n", wrenb_n, m_we_n);
    chk("model_csen_n", csen_n, m_cs_n);
    chk("model_addr_b", addr_b, m_addr);
    chk("model_data_b", data_b, m_data);
    chk("model_wr_ptr_gray", wr_ptr_gray, m_gray);
    chk("model_wr_level", wr_level, m_level);
    chk("model_full", full, m_full);
    chk("model_almost_full", almost_full, m_af);
    chk("model_in_ready", in_ready, !m_full);
    chk("model_ovf", ovf, m_ovf);
  end

  task automatic do_reset();
    @(negedge clkb);
    rst_n = 0; in_valid = 0; rd_ptr_gray = 0; ovf_clr = 0;
    @(negedge clkb);
    rst_n = 1;
  endtask

  initial begin
    bit found;
    rst_n = 1; in_valid = 0; in_data = 0; rd_ptr_gray = 0; ovf_clr = 0;
    #1 rst_n = 0;
    repeat (2) @(negedge clkb);
    chk("rst_wrenb_n", wrenb_n, 1);
    chk("rst_csen_n", csen_n, 1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_level", wr_level, 0);
    chk("rst_wr_ptr_gray", wr_ptr_gray, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1;
    @(negedge clkb);
    chk("rel_csen_n", csen_n, 0);
    chk("rel_in_ready", in_ready, 1);

    // single word
    in_valid = 1; in_data = 8'hA5;
    @(negedge clkb);
    in_valid = 0;
    chk("one_addr_b", addr_b, 0);
    chk("one_data_b", data_b, 8'hA5);
    chk("one_wrenb_n", wrenb_n, 0);
    chk("one_wr_level", wr_level, 1);
    chk("one_gray_early", wr_ptr_gray, 0);
    @(negedge clkb);
    chk("one_wrenb_end", wrenb_n, 1);
    chk("one_gray", wr_ptr_gray, 5'b00001);

    // 16-word burst to full
    do_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clkb);
      if (k > 0) begin
        chk("burst_wrenb_n", wrenb_n, 0);
        chk("burst_addr_b", addr_b, k - 1);
        chk("burst_level", wr_level, k);
        chk("burst_afull", almost_full, (k >= 12));
      end
      in_valid = 1; in_data = 8'(k);
    end
    @(negedge clkb);
    in_data = 8'hEE;
    chk("last_wrenb_n", wrenb_n, 0);
    chk("last_addr_b", addr_b, 15);
    chk("last_data_b", data_b, 8'h0F);
    chk("full_level", wr_level, 16);
    chk("full_flag", full, 1);
    chk("full_in_ready", in_ready, 0);

    // overflow while full, then clear
    repeat (3) begin
      @(negedge clkb);
      chk("ovf_wrenb_n", wrenb_n, 1);
      chk("ovf_flag", ovf, 1);
      chk("ovf_level", wr_level, 16);
    end
    in_valid = 0; ovf_clr = 1;
    @(negedge clkb);
    ovf_clr = 0;
    chk("ovf_cleared", ovf, 0);
    chk("ovf_data_kept", data_b, 8'h0F);

    // reader releases 4 words
    rd_ptr_gray = 5'b00110;
    found = 0;
    for (int i = 0; i < 3 && !found; i++) begin
      @(negedge clkb);
      if (in_ready) found = 1;
    end
    chk("release_in_time", found, 1);
    chk("release_level", wr_level, 12);
    in_valid = 1; in_data = 8'h5A;
    @(negedge clkb);
    in_valid = 0;
    chk("wrap_addr_b", addr_b, 0);
    chk("wrap_data_b", data_b, 8'h5A);
    chk("wrap_level", wr_level, 13);

    // reset in the middle of a burst
    do_reset();
    for (int k = 0; k < 7; k++) begin
      @(negedge clkb);
      in_valid = 1; in_data = 8'(8'h30 + k);
    end
    @(negedge clkb);
    chk("mid_level", wr_level, 7);
    chk("mid_wrenb_n", wrenb_n, 0);
    #2 rst_n = 0;
    #1;
    chk("abort_wrenb_n", wrenb_n, 1);
    chk("abort_level", wr_level, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clkb);
    rst_n = 1; in_data = 8'h77;
    @(negedge clkb);
    in_valid = 0;
    chk("after_rst_addr_b", addr_b, 0);
    chk("after_rst_data_b", data_b, 8'h77);
    chk("after_rst_wrenb_n", wrenb_n, 0);
    chk("after_rst_level", wr_level, 1);
    repeat (3) @(negedge clkb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
